// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: drives a 1-cycle-latency block RAM with byte enables,
// returns lane-extracted, extended load data and stalls the pipeline while a load is in flight.
module mem_access_unit #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_w,
    input  logic [1:0]        digit,
    input  logic              sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              ram_en,
    output logic [3:0]        ram_wea,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] width;
        logic       sgn;
    } loadCtx_t;

    state_t      state, stateNext;
    loadCtx_t    ctx;
    logic        legal, loadAccept, badReq;
    logic [3:0]  storeWea;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadVal;
    logic        unusedAddr;

    // High address bits fall off the RAM: accesses wrap modulo its size.
    assign unusedAddr = ^addr[31:RAM_AW+2];
    assign ram_addr   = addr[RAM_AW+1:2];

    always_comb begin
        legal = 1'b0;
        case (digit)
            2'b00:   legal = (addr[1:0] == 2'b00);
            2'b01:   legal = ~addr[0];
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Write data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        storeWea = 4'b0000;
        ram_din  = wdata;
        case (digit)
            2'b00: begin
                storeWea = 4'b1111;
                ram_din  = wdata;
            end
            2'b01: begin
                storeWea = addr[1] ? 4'b1100 : 4'b0011;
                ram_din  = {2{wdata[15:0]}};
            end
            default: begin
                storeWea = 4'b0001 << addr[1:0];
                ram_din  = {4{wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        stateNext  = state;
        ram_en     = 1'b0;
        ram_wea    = 4'b0000;
        stall      = 1'b0;
        badReq     = 1'b0;
        loadAccept = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        ram_en = 1'b1;
                        if (mem_w) begin
                            ram_wea = storeWea;
                        end else begin
                            stall      = 1'b1;
                            loadAccept = 1'b1;
                            stateNext  = LOAD_WAIT;
                        end
                    end else begin
                        badReq = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                stall     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        byteSel = ram_dout[{ctx.off, 3'b000} +: 8];
        halfSel = ctx.off[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (ctx.width)
            2'b00:   loadVal = ram_dout;
            2'b01:   loadVal = {{16{ctx.sgn & halfSel[15]}}, halfSel};
            default: loadVal = {{24{ctx.sgn & byteSel[7]}}, byteSel};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctx         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= stateNext;
            misalign    <= badReq;
            rdata_valid <= (state == LOAD_WAIT);
            if (state == LOAD_WAIT)
                rdata <= loadVal;
            if (loadAccept)
                ctx <= '{off: addr[1:0], width: digit, sgn: sign};
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM plus a byte-array reference memory,
// directed scenarios followed by randomized request streams.
module tb_mem_access_unit;

    localparam int RAM_AW = 12;
    localparam int MEM_BYTES = 4 << RAM_AW;

    logic              clk, rst, req_valid, mem_w, sign;
    logic [1:0]        digit;
    logic [31:0]       addr, wdata, rdata, ram_din, ram_dout;
    logic              stall, rdata_valid, misalign, ram_en;
    logic [3:0]        ram_wea;
    logic [RAM_AW-1:0] ram_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] lastRdata;
    logic [7:0]  refMem [0:MEM_BYTES-1];
    logic [31:0] ram    [0:(1<<RAM_AW)-1];

    mem_access_unit #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_w(mem_w), .digit(digit),
        .sign(sign), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .misalign(misalign), .ram_en(ram_en),
        .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Single-port read-first block RAM
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_wea[i]) ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
            ram_dout <= ram[ram_addr];
        end
    end

    function automatic int sizeOf(input logic [1:0] dg);
        return (dg == 2'b00) ? 4 : (dg == 2'b01) ? 2 : 1;
    endfunction

    function automatic bit isLegal(input logic [1:0] dg, input logic [31:0] a);
        if (dg == 2'b11) return 0;
        return (a % sizeOf(dg)) == 0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] dg, input logic sg, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = sizeOf(dg);
        v = 0;
        for (int j = 0; j < sz; j++)
            v = v | (32'(refMem[(a + j) % MEM_BYTES]) << (8 * j));
        if (sg && sz < 4 && v[8*sz-1])
            v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    // One request from IDLE, with every observable checked through to completion.
    task automatic issue(input logic w, input logic [1:0] dg, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bit legal;
        int sz, off;
        logic [3:0] expWea;
        logic [31:0] exp;
        legal = isLegal(dg, a);
        sz = sizeOf(dg);
        off = a % 4;
        @(negedge clk);
        req_valid = 1; mem_w = w; digit = dg; sign = sg; addr = a; wdata = wd;
        #1;
        checks++;
        if (ram_en !== legal || stall !== (legal && !w)) begin
            errors++;
            $display("FAIL accept a=%h dg=%0d w=%0d: ram_en=%b stall=%b want %b %b", a, dg, w, ram_en, stall, legal, legal && !w);
        end
        for (int i = 0; i < 4; i++) expWea[i] = legal && w && i >= off && i < off + sz;
        checks++;
        if (ram_wea !== expWea) begin
            errors++;
            $display("FAIL wea a=%h dg=%0d: got %b want %b", a, dg, ram_wea, expWea);
        end
        if (legal) begin
            checks++;
            if (ram_addr !== RAM_AW'((a / 4) % (1 << RAM_AW))) begin
                errors++;
                $display("FAIL ram_addr a=%h: got %h", a, ram_addr);
            end
        end
        if (legal && w) begin
            for (int i = off; i < off + sz; i++) begin
                checks++;
                if (ram_din[8*i +: 8] !== wd[8*(i-off) +: 8]) begin
                    errors++;
                    $display("FAIL din lane %0d a=%h: got %h want %h", i, a, ram_din[8*i +: 8], wd[8*(i-off) +: 8]);
                end
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if (misalign !== !legal) begin
            errors++;
            $display("FAIL misalign a=%h dg=%0d: got %b want %b", a, dg, misalign, !legal);
        end
        if (legal && w)
            for (int j = 0; j < sz; j++) refMem[(a + j) % MEM_BYTES] = wd[8*j +: 8];
        if (legal && !w) begin
            exp = refLoad(dg, sg, a);
            @(negedge clk); #1;
            checks++;
            if (stall !== 1 || ram_en !== 0 || ram_wea !== 0) begin
                errors++;
                $display("FAIL wait a=%h: stall=%b ram_en=%b wea=%b want 1 0 0", a, stall, ram_en, ram_wea);
            end
            @(posedge clk); #1;
            checks++;
            if (rdata_valid !== 1 || rdata !== exp || misalign !== 0) begin
                errors++;
                $display("FAIL load a=%h dg=%0d sg=%0d: rdata=%h vld=%b mis=%b want %h 1 0", a, dg, sg, rdata, rdata_valid, misalign, exp);
            end
            lastRdata = exp;
        end else begin
            checks++;
            if (rdata_valid !== 0 || rdata !== lastRdata) begin
                errors++;
                $display("FAIL hold a=%h: rdata=%h vld=%b want %h 0", a, rdata, rdata_valid, lastRdata);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; req_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 0 || rdata_valid !== 0 || misalign !== 0) begin
            errors++;
            $display("FAIL reset regs: rdata=%h vld=%b mis=%b want 0 0 0", rdata, rdata_valid, misalign);
        end
        checks++;
        if (stall !== 0 || ram_en !== 0 || ram_wea !== 0) begin
            errors++;
            $display("FAIL reset comb: stall=%b ram_en=%b wea=%b want 0 0 0", stall, ram_en, ram_wea);
        end
        rst = 0;
        lastRdata = 0;
    endtask

    task automatic test_directed;
        issue(1, 2'b00, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 2'b00, 0, 32'h10, 0);
        issue(1, 2'b10, 0, 32'h13, 32'h000000A5);
        issue(0, 2'b10, 1, 32'h13, 0);
        issue(0, 2'b10, 0, 32'h13, 0);
        issue(1, 2'b01, 0, 32'h22, 32'h00008001);
        issue(0, 2'b01, 1, 32'h22, 0);
        issue(0, 2'b01, 0, 32'h22, 0);
    endtask

    task automatic test_misalign;
        issue(0, 2'b01, 1, 32'h21, 0);
        issue(1, 2'b00, 0, 32'h06, 32'h12345678);
        issue(1, 2'b11, 0, 32'h00, 32'hCAFEF00D);
        issue(0, 2'b00, 0, 32'h04, 0);
        issue(0, 2'b00, 0, 32'h00, 0);
        // An illegal request followed by idle must pulse misalign only once
        checks++;
        if (misalign !== 0) begin
            errors++;
            $display("FAIL misalign pulse: got %b want 0", misalign);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] expA, expB;
        issue(1, 2'b00, 0, 32'h40, 32'h11112222);
        issue(1, 2'b00, 0, 32'h44, 32'h33334444);
        expA = refLoad(2'b00, 0, 32'h40);
        expB = refLoad(2'b00, 0, 32'h44);
        @(negedge clk);
        req_valid = 1; mem_w = 0; digit = 2'b00; sign = 0; addr = 32'h40;
        @(negedge clk);
        addr = 32'h44; #1;
        checks++;
        if (stall !== 1 || ram_en !== 0) begin
            errors++;
            $display("FAIL b2b T+1: stall=%b ram_en=%b want 1 0", stall, ram_en);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata_valid !== 1 || rdata !== expA) begin
            errors++;
            $display("FAIL b2b first: rdata=%h vld=%b want %h 1", rdata, rdata_valid, expA);
        end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1 || ram_en !== 1 || ram_wea !== 0) begin
            errors++;
            $display("FAIL b2b T+2 accept: stall=%b ram_en=%b wea=%b want 1 1 0", stall, ram_en, ram_wea);
        end
        @(negedge clk);
        mem_w = 1; wdata = 32'h5555AAAA; #1;
        checks++;
        if (rdata_valid !== 0 || ram_en !== 0 || ram_wea !== 0) begin
            errors++;
            $display("FAIL b2b store in wait: vld=%b ram_en=%b wea=%b want 0 0 0", rdata_valid, ram_en, ram_wea);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata_valid !== 1 || rdata !== expB) begin
            errors++;
            $display("FAIL b2b second: rdata=%h vld=%b want %h 1", rdata, rdata_valid, expB);
        end
        lastRdata = expB;
        @(negedge clk); #1;
        checks++;
        if (stall !== 0 || ram_en !== 1 || ram_wea !== 4'b1111) begin
            errors++;
            $display("FAIL b2b store accept: stall=%b ram_en=%b wea=%b want 0 1 1111", stall, ram_en, ram_wea);
        end
        @(posedge clk); #1;
        req_valid = 0;
        for (int j = 0; j < 4; j++) refMem[32'h44 + j] = wdata[8*j +: 8];
        issue(0, 2'b00, 0, 32'h44, 0);
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        req_valid = 1; mem_w = 0; digit = 2'b00; sign = 0; addr = 32'h10;
        @(negedge clk);
        req_valid = 0; rst = 1;
        @(posedge clk); #1;
        checks++;
        if (rdata_valid !== 0 || rdata !== 0) begin
            errors++;
            $display("FAIL rst in wait: rdata=%h vld=%b want 0 0", rdata, rdata_valid);
        end
        rst = 0;
        lastRdata = 0;
        @(negedge clk); #1;
        checks++;
        if (stall !== 0 || rdata_valid !== 0) begin
            errors++;
            $display("FAIL rst back to idle: stall=%b vld=%b want 0 0", stall, rdata_valid);
        end
        issue(0, 2'b10, 1, 32'h13, 0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & ~(MEM_BYTES - 1));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    initial begin
        rst = 1; req_valid = 0; mem_w = 0; digit = 0; sign = 0; addr = 0; wdata = 0;
        lastRdata = 0;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 0;
        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 0;
        ram_dout = 0;
        test_reset;
        test_directed;
        test_misalign;
        test_back_to_back;
        test_reset_in_wait;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
